// File: rtl/seq_divider_16x8.sv
// Radix-2 restoring divider, 16-bit dividend by 8-bit divisor.
// One quotient bit per clock, start/done handshake, 3-bit state feed.
module seq_divider_16x8 #(
   parameter int N_WIDTH = 16,
   parameter int D_WIDTH = 8
) (
   input  logic               clk,
   input  logic               aclr_n,
   input  logic               start,
   input  logic [N_WIDTH-1:0] dividend,
   input  logic [D_WIDTH-1:0] divisor,
   output logic               busy,
   output logic               done,
   output logic               dbz,
   output logic [N_WIDTH-1:0] quotient,
   output logic [D_WIDTH-1:0] remainder,
   output logic [2:0]         state_out
);

   localparam int C_W = $clog2(N_WIDTH);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CALC = 3'd1,
      DONE = 3'd2,
      ERR  = 3'd3
   } state_t;

   state_t             state_q, state_d;
   logic [C_W-1:0]     cnt_q, cnt_d;
   logic [N_WIDTH-1:0] q_q, q_d;
   logic [D_WIDTH-1:0] d_q, d_d;
   logic [D_WIDTH:0]   r_q, r_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               dbz_q, dbz_d;
   logic [N_WIDTH-1:0] quo_q, quo_d;
   logic [D_WIDTH-1:0] rem_q, rem_d;

   // R carries one guard bit so the trial difference sign is explicit
   logic [D_WIDTH+1:0] r_sh;
   logic [N_WIDTH-1:0] q_sh;
   logic [D_WIDTH+1:0] t;

   // Next-state and datapath: accept, iterate, finish
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      d_d     = d_q;
      r_d     = r_q;
      done_d  = done_q;
      dbz_d   = dbz_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      r_sh    = {r_q, q_q[N_WIDTH-1]};
      q_sh    = {q_q[N_WIDTH-2:0], 1'b0};
      t       = r_sh - {2'b00, d_q};
      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               q_d    = dividend;
               d_d    = divisor;
               r_d    = '0;
               cnt_d  = '0;
               done_d = 1'b0;
               dbz_d  = 1'b0;
               if (divisor == '0) begin
                  state_d = ERR;
                  done_d  = 1'b1;
                  dbz_d   = 1'b1;
                  quo_d   = '1;
                  rem_d   = '0;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (!t[D_WIDTH+1]) begin
               r_d = t[D_WIDTH:0];
               q_d = {q_sh[N_WIDTH-1:1], 1'b1};
            end else begin
               r_d = r_sh[D_WIDTH:0];
               q_d = q_sh;
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == C_W'(N_WIDTH - 1)) begin
               quo_d   = q_d;
               rem_d   = r_d[D_WIDTH-1:0];
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == CALC);
   end

   // State and result registers, cleared asynchronously
   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         q_q     <= '0;
         d_q     <= '0;
         r_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         d_q     <= d_d;
         r_q     <= r_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign dbz       = dbz_q;
   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign state_out = state_q;

endmodule

// File: tb/tb_seq_divider_16x8.sv
// Directed bench for seq_divider_16x8.
// Linear stimulus, immediate assertions at each check point.
module tb_seq_divider_16x8;

   logic        clk;
   logic        aclr_n;
   logic        start;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        busy;
   logic        done;
   logic        dbz;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic [2:0]  state_out;

   int compared;
   int mism;
   logic [15:0] last_q;

   seq_divider_16x8 dut (
      .clk       (clk),
      .aclr_n    (aclr_n),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .dbz       (dbz),
      .quotient  (quotient),
      .remainder (remainder),
      .state_out (state_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mism++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run(input logic [15:0] a, input logic [7:0] b,
                      input int poke);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      step();
      start    = 1'b0;
      dividend = 16'h5A5A;
      divisor  = 8'hC3;
      check("acc_busy", {31'd0, busy}, 32'd1);
      check("acc_done", {31'd0, done}, 32'd0);
      check("acc_state", {29'd0, state_out}, 32'd1);
      check("acc_quo_hold", {16'd0, quotient}, {16'd0, last_q});
      for (int i = 1; i < 16; i++) begin
         if (i == poke) begin
            start    = 1'b1;
            dividend = 16'd999;
            divisor  = 8'd5;
         end
         step();
         start = 1'b0;
         check("calc_busy", {31'd0, busy}, 32'd1);
         check("calc_nodone", {31'd0, done}, 32'd0);
      end
      step();
      check("fin_done", {31'd0, done}, 32'd1);
      check("fin_busy", {31'd0, busy}, 32'd0);
      check("fin_dbz", {31'd0, dbz}, 32'd0);
      check("fin_state", {29'd0, state_out}, 32'd2);
   endtask

   task automatic res(input string tag, input logic [15:0] eq,
                      input logic [7:0] er);
      check({tag, "_q"}, {16'd0, quotient}, {16'd0, eq});
      check({tag, "_r"}, {24'd0, remainder}, {24'd0, er});
      last_q = eq;
   endtask

   initial begin
      logic [15:0] ra;
      logic [7:0]  rb;
      logic [23:0] prod;
      compared = 0;
      mism     = 0;
      last_q   = 16'd0;
      aclr_n   = 1'b0;
      start    = 1'b1;
      dividend = 16'd1000;
      divisor  = 8'd7;
      step();
      step();
      check("rst_state", {29'd0, state_out}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_dbz", {31'd0, dbz}, 32'd0);
      check("rst_quo", {16'd0, quotient}, 32'd0);
      check("rst_rem", {24'd0, remainder}, 32'd0);
      start  = 1'b0;
      #2 aclr_n = 1'b1;
      step();
      check("idle_state", {29'd0, state_out}, 32'd0);

      run(16'd1000, 8'd7, 0);
      res("d1000_7", 16'd142, 8'd6);
      step();
      check("done_hold", {29'd0, state_out}, 32'd2);
      run(16'd300, 8'd17, 5);
      res("d300_17", 16'd17, 8'd11);
      run(16'd65535, 8'd255, 0);
      res("dmax_255", 16'd257, 8'd0);
      run(16'd65535, 8'd1, 0);
      res("dmax_1", 16'd65535, 8'd0);
      run(16'd5, 8'd9, 0);
      res("d5_9", 16'd0, 8'd5);
      run(16'd0, 8'd13, 0);
      res("d0_13", 16'd0, 8'd0);

      dividend = 16'd1234;
      divisor  = 8'd0;
      start    = 1'b1;
      step();
      start = 1'b0;
      check("err_state", {29'd0, state_out}, 32'd3);
      check("err_done", {31'd0, done}, 32'd1);
      check("err_dbz", {31'd0, dbz}, 32'd1);
      check("err_busy", {31'd0, busy}, 32'd0);
      check("err_quo", {16'd0, quotient}, 32'h0000FFFF);
      check("err_rem", {24'd0, remainder}, 32'd0);
      last_q = 16'hFFFF;
      step();
      step();
      check("err_hold", {29'd0, state_out}, 32'd3);
      run(16'd100, 8'd10, 0);
      res("d100_10", 16'd10, 8'd0);

      dividend = 16'd50000;
      divisor  = 8'd3;
      start    = 1'b1;
      step();
      start = 1'b0;
      repeat (8) step();
      check("mid_busy", {31'd0, busy}, 32'd1);
      #2 aclr_n = 1'b0;
      #1;
      check("arst_state", {29'd0, state_out}, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      check("arst_quo", {16'd0, quotient}, 32'd0);
      check("arst_rem", {24'd0, remainder}, 32'd0);
      @(posedge clk);
      #3 aclr_n = 1'b1;
      step();
      step();
      check("arst_idle", {29'd0, state_out}, 32'd0);
      check("arst_nodone", {31'd0, done}, 32'd0);
      last_q = 16'd0;
      run(16'd50000, 8'd3, 0);
      res("d50000_3", 16'd16666, 8'd2);

      for (int n = 0; n < 8; n++) begin
         ra = 16'($urandom);
         rb = 8'($urandom_range(1, 255));
         run(ra, rb, 0);
         prod = 24'(quotient) * 24'(rb) + 24'(remainder);
         check("rnd_inv", {8'd0, prod}, {16'd0, ra});
         check("rnd_rlt", {31'd0, remainder < rb}, 32'd1);
         last_q = quotient;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mism);
      $finish;
   end

endmodule
